// File: rtl/mem_bus_seq.sv
// mem_bus_seq: sequences the shared bidirectional data bus between the working
// register and memory. Turns single-cycle load/store requests into
// mutually-exclusive mem_write/mem_read strobes, inserts turnaround idle
// cycles on a change of direction, waits for mem_ack with a timeout, and
// reports done/error to the control unit.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_load   request DATA->WREG transfer (sampled only in IDLE)
//   req_store  request WREG->DATA transfer (sampled only in IDLE)
//   mem_ack    memory data valid (load) / data accepted (store)
//   mem_write  bidir port control: routes DATA->WREG
//   mem_read   bidir port control: drives WREG onto DATA
//   wreg_load  one-cycle capture enable for the working register
//   busy       high in every state except IDLE
//   done       one-cycle pulse on transfer completion
//   error      one-cycle pulse on timeout or simultaneous requests
module mem_bus_seq #(
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned TURN_CYC    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_load,
    input  logic req_store,
    input  logic mem_ack,
    output logic mem_write,
    output logic mem_read,
    output logic wreg_load,
    output logic busy,
    output logic done,
    output logic error
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned TW = $clog2(TURN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TURN, S_LOAD, S_STORE, S_DONE_L, S_DONE_S, S_ERR
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE, DIR_LOAD, DIR_STORE
    } dir_t;

    state_t         state, state_nx;
    dir_t           last_dir, last_dir_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [TW-1:0]  tcnt, tcnt_nx;
    logic           pend_load, pend_load_nx;

    always_comb begin
        state_nx     = state;
        last_dir_nx  = last_dir;
        cnt_nx       = cnt;
        tcnt_nx      = tcnt;
        pend_load_nx = pend_load;
        case (state)
            S_IDLE: begin
                if (req_load && req_store) begin
                    state_nx = S_ERR;
                end else if (req_load) begin
                    pend_load_nx = 1'b1;
                    cnt_nx       = '0;
                    tcnt_nx      = '0;
                    state_nx     = (last_dir == DIR_STORE) ? S_TURN : S_LOAD;
                end else if (req_store) begin
                    pend_load_nx = 1'b0;
                    cnt_nx       = '0;
                    tcnt_nx      = '0;
                    state_nx     = (last_dir == DIR_LOAD) ? S_TURN : S_STORE;
                end
            end
            S_TURN: begin
                if (tcnt == TW'(TURN_CYC - 1)) begin
                    cnt_nx   = '0;
                    state_nx = pend_load ? S_LOAD : S_STORE;
                end else begin
                    tcnt_nx = tcnt + TW'(1);
                end
            end
            S_LOAD, S_STORE: begin
                // cnt holds the number of wait cycles already spent; ack wins
                // over timeout on the final cycle.
                if (mem_ack) begin
                    state_nx = (state == S_LOAD) ? S_DONE_L : S_DONE_S;
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_nx    = S_ERR;
                    last_dir_nx = (state == S_LOAD) ? DIR_LOAD : DIR_STORE;
                end else if (cnt != CW'(TIMEOUT_CYC)) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_DONE_L: begin
                last_dir_nx = DIR_LOAD;
                state_nx    = S_IDLE;
            end
            S_DONE_S: begin
                last_dir_nx = DIR_STORE;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            last_dir  <= DIR_NONE;
            cnt       <= '0;
            tcnt      <= '0;
            pend_load <= 1'b0;
        end else begin
            state     <= state_nx;
            last_dir  <= last_dir_nx;
            cnt       <= cnt_nx;
            tcnt      <= tcnt_nx;
            pend_load <= pend_load_nx;
        end
    end

    // Outputs are registered decodes of the next state, so they line up with
    // the state they belong to and carry no combinational glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            wreg_load <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_write <= (state_nx == S_LOAD)  || (state_nx == S_DONE_L);
            mem_read  <= (state_nx == S_STORE) || (state_nx == S_DONE_S);
            wreg_load <= (state_nx == S_DONE_L);
            busy      <= (state_nx != S_IDLE);
            done      <= (state_nx == S_DONE_L) || (state_nx == S_DONE_S);
            error     <= (state_nx == S_ERR);
        end
    end

endmodule

// File: tb/tb_mem_bus_seq.sv
// Directed bench for mem_bus_seq: a vector table covers reset, load/store
// timing, turnaround and simultaneous requests; hand-written sequences cover
// timeout and asynchronous reset mid-transfer.
module tb_mem_bus_seq;

    logic clk = 1'b0;
    logic rst_n, req_load, req_store, mem_ack;
    logic mem_write, mem_read, wreg_load, busy, done, error;

    int n_vec = 0;
    int n_err = 0;

    mem_bus_seq #(.TIMEOUT_CYC(15), .TURN_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_load(req_load), .req_store(req_store),
        .mem_ack(mem_ack), .mem_write(mem_write), .mem_read(mem_read),
        .wreg_load(wreg_load), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // expected output word: {mem_write, mem_read, wreg_load, busy, done, error}
    localparam logic [5:0] O_IDLE = 6'b000000;
    localparam logic [5:0] O_LOAD = 6'b100100;
    localparam logic [5:0] O_DNL  = 6'b101110;
    localparam logic [5:0] O_STOR = 6'b010100;
    localparam logic [5:0] O_DNS  = 6'b010110;
    localparam logic [5:0] O_TURN = 6'b000100;
    localparam logic [5:0] O_ERR  = 6'b000101;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       rl;
        logic       rs;
        logic       ack;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic l, logic s, logic a, logic [5:0] e);
        vec_t v;
        v.name = n; v.rst_n = r; v.rl = l; v.rs = s; v.ack = a; v.exp = e;
        return v;
    endfunction

    task automatic check(string name, logic [5:0] exp);
        logic [5:0] got;
        got = {mem_write, mem_read, wreg_load, busy, done, error};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got wr,rd,wl,busy,done,err=%b expected %b", name, got, exp);
        end
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(logic r, logic l, logic s, logic a);
        rst_n = r; req_load = l; req_store = s; mem_ack = a;
        @(posedge clk);
        #1;
    endtask

    // Strobes must never overlap, sampled mid-cycle.
    always @(negedge clk) begin
        n_vec++;
        if (mem_write === 1'b1 && mem_read === 1'b1) begin
            n_err++;
            $display("FAIL strobe_overlap: got wr=1 rd=1 expected not both");
        end
    end

    initial begin
        // Reset and idle
        vecs.push_back(mk("rst_a",      0, 1, 0, 1, O_IDLE));
        vecs.push_back(mk("rst_b",      0, 0, 1, 1, O_IDLE));
        vecs.push_back(mk("rst_c",      0, 1, 1, 0, O_IDLE));
        vecs.push_back(mk("idle_1",     1, 0, 0, 0, O_IDLE));
        vecs.push_back(mk("idle_2",     1, 0, 0, 0, O_IDLE));
        vecs.push_back(mk("idle_3",     1, 0, 0, 0, O_IDLE));
        // Load after reset, ack on 2nd LOAD cycle, no TURN
        vecs.push_back(mk("ld_load1",   1, 1, 0, 0, O_LOAD));
        vecs.push_back(mk("ld_load2",   1, 0, 1, 0, O_LOAD));   // req_store ignored while busy
        vecs.push_back(mk("ld_done",    1, 0, 0, 1, O_DNL));
        vecs.push_back(mk("ld_idle",    1, 0, 0, 0, O_IDLE));
        // Load then load: no TURN
        vecs.push_back(mk("ll_load",    1, 1, 0, 0, O_LOAD));
        vecs.push_back(mk("ll_done",    1, 0, 0, 1, O_DNL));
        vecs.push_back(mk("ll_idle",    1, 0, 0, 0, O_IDLE));
        vecs.push_back(mk("idle_ack",   1, 0, 0, 1, O_IDLE));   // ack in IDLE ignored
        // Load -> store: one TURN cycle, ack during TURN ignored
        vecs.push_back(mk("ls_turn",    1, 0, 1, 0, O_TURN));
        vecs.push_back(mk("ls_store",   1, 0, 0, 1, O_STOR));
        vecs.push_back(mk("ls_done",    1, 0, 0, 1, O_DNS));
        vecs.push_back(mk("ls_idle",    1, 0, 0, 0, O_IDLE));
        // Store -> load: exactly one TURN cycle
        vecs.push_back(mk("sl_turn",    1, 1, 0, 0, O_TURN));
        vecs.push_back(mk("sl_load",    1, 0, 0, 1, O_LOAD));
        vecs.push_back(mk("sl_done",    1, 0, 0, 1, O_DNL));
        vecs.push_back(mk("sl_idle",    1, 0, 0, 0, O_IDLE));
        // Simultaneous requests: error, last_dir stays LOAD
        vecs.push_back(mk("sim_err",    1, 1, 1, 0, O_ERR));
        vecs.push_back(mk("sim_idle",   1, 0, 0, 1, O_IDLE));
        vecs.push_back(mk("sim_load",   1, 1, 0, 0, O_LOAD));   // no TURN: dir unchanged
        vecs.push_back(mk("sim_done",   1, 0, 0, 1, O_DNL));
        vecs.push_back(mk("sim_idle2",  1, 0, 0, 0, O_IDLE));

        rst_n = 1'b0; req_load = 1'b1; req_store = 1'b1; mem_ack = 1'b1;
        #1;
        check("rst_async", O_IDLE);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].rl, vecs[i].rs, vecs[i].ack);
            check(vecs[i].name, vecs[i].exp);
        end

        // Timeout: store after load -> TURN, 15 STORE cycles, ERR, IDLE
        step(1, 0, 1, 0);
        check("to_turn", O_TURN);
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0, 0);
            check($sformatf("to_store%0d", i), O_STOR);
        end
        step(1, 0, 0, 0);
        check("to_err", O_ERR);
        step(1, 0, 0, 0);
        check("to_idle", O_IDLE);
        // last_dir is now STORE (attempted): another store needs no TURN
        step(1, 0, 1, 0);
        check("to_store_again", O_STOR);
        step(1, 0, 0, 1);
        check("to_store_done", O_DNS);
        step(1, 0, 0, 0);
        check("to_store_idle", O_IDLE);

        // Async reset mid-LOAD: store -> load needs TURN first
        step(1, 1, 0, 0);
        check("ar_turn", O_TURN);
        step(1, 0, 0, 0);
        check("ar_load", O_LOAD);
        #2 rst_n = 1'b0;
        #1;
        check("ar_drop", O_IDLE);
        step(0, 0, 0, 0);
        check("ar_held", O_IDLE);
        step(1, 0, 0, 0);
        check("ar_idle", O_IDLE);
        // last_dir back to NONE: load goes straight to LOAD
        step(1, 1, 0, 0);
        check("ar_load_noturn", O_LOAD);
        step(1, 0, 0, 1);
        check("ar_done", O_DNL);
        step(1, 0, 0, 0);
        check("ar_final_idle", O_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_seq.md
Name: mem_bus_seq

Overview:
- Sequences the shared bidirectional data bus between the working register and memory.
- Turns single-cycle load/store requests from the control unit into clean mem_write/mem_read strobes for the bidirectional port. The strobes are never both high.
- Inserts bus turnaround cycles on direction change, waits for a memory acknowledge, and generates the working-register load enable.
- Reports completion or timeout to the control unit.

Parameters:
- TIMEOUT_CYC, 15, max cycles in LOAD/STORE waiting for mem_ack before abort (>=1).
- TURN_CYC, 1, idle cycles (both strobes 0) inserted when transfer direction differs from previous transfer (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_load  input  1  request DATA->WREG transfer; sampled only in IDLE.
- req_store  input  1  request WREG->DATA transfer; sampled only in IDLE.
- mem_ack  input  1  memory has data valid (load) / has accepted data (store).
- mem_write  output  1  to bidir port: 1 with mem_read=0 routes DATA->WREG.
- mem_read  output  1  to bidir port: 1 with mem_write=0 drives WREG onto DATA.
- wreg_load  output  1  one-cycle enable: working register captures to_wreg.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, transfer completed.
- error  output  1  one-cycle pulse: timeout or simultaneous requests.

Behaviour:
- All outputs registered (Moore), decoded from state.
- Reset (async, rst_n=0): state IDLE, cycle counter 0, last_dir NONE, all outputs 0. Reset asserted mid-transfer drops both strobes immediately.
- States: IDLE, TURN, LOAD, STORE, DONE_L, DONE_S, ERR.
- IDLE:
  - Both strobes 0.
  - req_load&req_store both 1 -> ERR; no transfer; last_dir unchanged.
  - req_load only -> if last_dir==STORE go TURN (pending LOAD), else LOAD.
  - req_store only -> if last_dir==LOAD go TURN (pending STORE), else STORE.
- TURN:
  - Strobes 0; stays TURN_CYC cycles, then enters the pending op.
  - mem_ack ignored.
- LOAD:
  - mem_write=1, mem_read=0; counter increments each cycle.
  - mem_ack=1 -> DONE_L.
  - Counter reaches TIMEOUT_CYC with no ack -> ERR.
- DONE_L:
  - mem_write held 1 (bus stays routed); wreg_load=1; done=1.
  - last_dir<=LOAD; next IDLE.
- STORE:
  - mem_read=1, mem_write=0; counter behaves as in LOAD.
  - mem_ack -> DONE_S.
  - Timeout -> ERR.
- DONE_S:
  - mem_read held 1 (data held on bus one extra cycle); done=1.
  - last_dir<=STORE; next IDLE.
- ERR:
  - Strobes 0, error=1 for one cycle; next IDLE.
  - After a timeout, last_dir<=direction attempted.
- Counter: width clog2(TIMEOUT_CYC+1); cleared on entry to LOAD/STORE; saturates, no wrap.
- Latency:
  - Request at IDLE edge N, same direction, ack in first LOAD cycle: LOAD at N+1, DONE at N+2, IDLE at N+3.
  - A direction change adds TURN_CYC cycles.
- Requests while busy are ignored (not queued). The control unit holds or re-issues them after done/error.
- mem_ack asserted in IDLE/TURN/DONE/ERR is ignored.
- Invariant: mem_write&mem_read never 1 in any cycle, including reset release.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, idle 3 cycles -> outputs stay 0, busy=0.
- Load after reset: req_load pulse, mem_ack on 2nd LOAD cycle -> mem_write=1 for 3 cycles (2 LOAD + DONE_L). wreg_load=1 and done=1 exactly in the 3rd. No TURN cycle.
- Direction change: store then load, TURN_CYC=1, ack immediate -> exactly one cycle with both strobes 0 and busy=1 between DONE_S and the first LOAD. Load then load -> no TURN.
- Timeout: TIMEOUT_CYC=15, req_store, mem_ack held 0 -> mem_read high 15 cycles, then error=1 one cycle with strobes 0, done never 1, back to IDLE.
- Simultaneous req_load=req_store=1 -> error pulse next cycle, no strobe ever asserted, last_dir unchanged.
- Async reset mid-LOAD (rst_n low between edges) -> mem_write falls without waiting for clk; after release the next load proceeds with no TURN.
